// File: rtl/clk_gen_pkg.sv
// Shared definitions for the clock generation chain: meter FSM states and
// the default gate length / expected count windows for each divider tap.
package clk_gen_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    MEASURE = 2'd2,
    REPORT  = 2'd3
  } meter_state_e;

  // Default gate window in system clock cycles.
  localparam int GATE_DEFAULT = 1024;

  // Expected edge counts per divider tap over a GATE_DEFAULT window
  // (nominal count +/- 6 edges of tolerance).
  localparam int DIV4_EXP_MIN  = 250;
  localparam int DIV4_EXP_MAX  = 262;
  localparam int DIV8_EXP_MIN  = 122;
  localparam int DIV8_EXP_MAX  = 134;
  localparam int DIV16_EXP_MIN = 58;
  localparam int DIV16_EXP_MAX = 70;

endpackage : clk_gen_pkg

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous input followed by a
// previous-sample flop that yields a one-cycle rising-edge pulse.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift the async input through the synchronizer chain and keep the last
  // synchronized sample for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {SYNC_STAGES{1'b0}};
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule : sync_edge_det

// File: rtl/clk_freq_meter.sv
// Clock frequency meter: counts rising edges of a divided clock over a fixed
// gate window of system clock cycles and reports count, range and faults.
module clk_freq_meter
  import clk_gen_pkg::*;
#(
  parameter int GATE_CYCLES = GATE_DEFAULT,
  parameter int CNT_W       = 16,
  parameter int EXP_MIN     = DIV4_EXP_MIN,
  parameter int EXP_MAX     = DIV4_EXP_MAX,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             continuous,
  input  logic             meas_in,
  output logic             busy,
  output logic [CNT_W-1:0] count_out,
  output logic             count_valid,
  output logic             in_range,
  output logic             overflow,
  output logic             stuck
);

  localparam int GW = $clog2(GATE_CYCLES);
  localparam int SW = $clog2(SYNC_STAGES + 1);

  localparam logic [GW-1:0]    GATE_LAST   = GW'(GATE_CYCLES - 1);
  localparam logic [SW-1:0]    SETTLE_LAST = SW'(SYNC_STAGES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LO      = CNT_W'(EXP_MIN);
  localparam logic [CNT_W-1:0] CNT_HI      = CNT_W'(EXP_MAX);

  meter_state_e     state_q, state_d;
  logic [GW-1:0]    gate_q, gate_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] count_out_q, count_out_d;
  logic             valid_q, valid_d;
  logic             in_range_q, in_range_d;
  logic             overflow_q, overflow_d;
  logic             stuck_q, stuck_d;
  logic             rise_s;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .d_i    (meas_in),
    .rise_o (rise_s)
  );

  // Next-state, gate/edge counting and report capture.
  always_comb begin
    state_d     = state_q;
    gate_d      = gate_q;
    settle_d    = settle_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    count_out_d = count_out_q;
    valid_d     = 1'b0;
    in_range_d  = in_range_q;
    overflow_d  = overflow_q;
    stuck_d     = stuck_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = SETTLE;
          settle_d = {SW{1'b0}};
        end else begin
          state_d  = IDLE;
        end
      end

      // Flush samples taken before the window; edges here are discarded.
      SETTLE: begin
        cnt_d  = {CNT_W{1'b0}};
        ovf_d  = 1'b0;
        gate_d = {GW{1'b0}};
        if (settle_q == SETTLE_LAST) begin
          state_d = MEASURE;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end

      // Saturating edge count; a rise on the last gate cycle still counts.
      MEASURE: begin
        if (rise_s) begin
          if (cnt_q == CNT_MAX) begin
            ovf_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
        if (gate_q == GATE_LAST) begin
          state_d = REPORT;
        end else begin
          gate_d = gate_q + GW'(1);
        end
      end

      REPORT: begin
        count_out_d = cnt_q;
        overflow_d  = ovf_q;
        stuck_d     = (cnt_q == {CNT_W{1'b0}});
        in_range_d  = ~ovf_q && (cnt_q >= CNT_LO) && (cnt_q <= CNT_HI);
        valid_d     = 1'b1;
        if (continuous) begin
          state_d  = SETTLE;
          settle_d = {SW{1'b0}};
        end else begin
          state_d  = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      gate_q      <= {GW{1'b0}};
      settle_q    <= {SW{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
      count_out_q <= {CNT_W{1'b0}};
      valid_q     <= 1'b0;
      in_range_q  <= 1'b0;
      overflow_q  <= 1'b0;
      stuck_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      gate_q      <= gate_d;
      settle_q    <= settle_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      busy_q      <= busy_d;
      count_out_q <= count_out_d;
      valid_q     <= valid_d;
      in_range_q  <= in_range_d;
      overflow_q  <= overflow_d;
      stuck_q     <= stuck_d;
    end
  end

  assign busy        = busy_q;
  assign count_out   = count_out_q;
  assign count_valid = valid_q;
  assign in_range    = in_range_q;
  assign overflow    = overflow_q;
  assign stuck       = stuck_q;

endmodule : clk_freq_meter

// File: tb/tb_clk_freq_meter.sv
// Directed bench for clk_freq_meter: a default-width meter and a 4-bit
// counter variant share the same stimulus. Cycle k = 0 is the start cycle.
module tb_clk_freq_meter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        continuous;
  logic        meas_in;

  logic        busy, count_valid, in_range, overflow, stuck;
  logic [15:0] count_out;
  logic        busy4, count_valid4, in_range4, overflow4, stuck4;
  logic [3:0]  count_out4;

  int n_checks = 0;
  int n_fail   = 0;

  int v_k[$];
  int v_cnt[$];
  int v_rng[$];
  int v_ovf[$];
  int v_stk[$];
  int d4_k, d4_cnt, d4_ovf, d4_rng, d4_stk;
  int busy_at1, busy_end;

  always #5 clk = ~clk;

  clk_freq_meter dut (
    .clk(clk), .reset_n(reset_n), .start(start), .continuous(continuous),
    .meas_in(meas_in), .busy(busy), .count_out(count_out),
    .count_valid(count_valid), .in_range(in_range), .overflow(overflow),
    .stuck(stuck)
  );

  clk_freq_meter #(.CNT_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .start(start), .continuous(continuous),
    .meas_in(meas_in), .busy(busy4), .count_out(count_out4),
    .count_valid(count_valid4), .in_range(in_range4), .overflow(overflow4),
    .stuck(stuck4)
  );

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // meas_in pattern per mode for cycle k (value held during cycle k).
  function automatic logic pat(input int mode, input int k);
    case (mode)
      0:       return ((k % 4) < 2);                 // clk/4
      1:       return 1'b0;                          // stuck low
      2:       return ((k % 8) < 4);                 // clk/8
      3:       return ((k >= 1 && k <= 1021 && (k % 4) == 1) ||
                       k == 1024 || k == 1026);      // 256 pulses + boundary
      default: return 1'b0;
    endcase
  endfunction

  // Drive one run starting with a start pulse at k=0 and record every report.
  task automatic run(input int mode, input int ncyc, input int cont_len,
                     input int start2_k, input int rst_k);
    v_k.delete(); v_cnt.delete(); v_rng.delete(); v_ovf.delete(); v_stk.delete();
    d4_k = -1; d4_cnt = -1; d4_ovf = -1; d4_rng = -1; d4_stk = -1;
    busy_at1 = -1;
    for (int k = 0; k < ncyc; k++) begin
      start      = (k == 0) || (k == start2_k);
      continuous = (k < cont_len);
      meas_in    = pat(mode, k);
      if (k == rst_k) begin
        reset_n = 1'b0;
        #1;
        check_eq("rst_count_out", count_out, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_valid", count_valid, 0);
        check_eq("rst_in_range", in_range, 0);
      end else if (k == rst_k + 3) begin
        reset_n = 1'b1;
      end
      if (k == 1) busy_at1 = busy;
      if (count_valid) begin
        v_k.push_back(k);
        v_cnt.push_back(int'(count_out));
        v_rng.push_back(int'(in_range));
        v_ovf.push_back(int'(overflow));
        v_stk.push_back(int'(stuck));
      end
      if (count_valid4 && d4_k < 0) begin
        d4_k   = k;
        d4_cnt = int'(count_out4);
        d4_ovf = int'(overflow4);
        d4_rng = int'(in_range4);
        d4_stk = int'(stuck4);
      end
      @(posedge clk);
      #1;
    end
    busy_end   = busy;
    start      = 1'b0;
    continuous = 1'b0;
    meas_in    = 1'b0;
    reset_n    = 1'b1;
  endtask

  initial begin
    reset_n    = 1'b0;
    start      = 1'b0;
    continuous = 1'b0;
    meas_in    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_busy", busy, 0);
    check_eq("reset_count_out", count_out, 0);
    check_eq("reset_valid", count_valid, 0);
    check_eq("reset_in_range", in_range, 0);
    check_eq("reset_overflow", overflow, 0);
    check_eq("reset_stuck", stuck, 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // clk/4: 256 edges, latency 1028; 4-bit variant saturates.
    run(0, 1100, 0, -1, -1);
    check_eq("div4_nvalid", v_k.size(), 1);
    if (v_k.size() > 0) begin
      check_eq("div4_latency", v_k[0], 1028);
      check_eq("div4_count", v_cnt[0], 256);
      check_eq("div4_in_range", v_rng[0], 1);
      check_eq("div4_overflow", v_ovf[0], 0);
      check_eq("div4_stuck", v_stk[0], 0);
    end
    check_eq("div4_busy_at1", busy_at1, 1);
    check_eq("div4_busy_end", busy_end, 0);
    check_eq("w4_latency", d4_k, 1028);
    check_eq("w4_count", d4_cnt, 15);
    check_eq("w4_overflow", d4_ovf, 1);
    check_eq("w4_in_range", d4_rng, 0);
    check_eq("w4_stuck", d4_stk, 0);
    check_eq("div4_hold", count_out, 256);

    // Reset mid-MEASURE: outputs clear at once, no report follows.
    run(0, 1200, 0, -1, 500);
    check_eq("rst_nvalid", v_k.size(), 0);
    check_eq("rst_busy_end", busy_end, 0);

    // Fresh measurement after the abort.
    run(0, 1100, 0, -1, -1);
    check_eq("post_rst_nvalid", v_k.size(), 1);
    if (v_k.size() > 0) begin
      check_eq("post_rst_latency", v_k[0], 1028);
      check_eq("post_rst_count", v_cnt[0], 256);
    end

    // Stuck-low input.
    run(1, 1100, 0, -1, -1);
    check_eq("stuck_nvalid", v_k.size(), 1);
    if (v_k.size() > 0) begin
      check_eq("stuck_count", v_cnt[0], 0);
      check_eq("stuck_flag", v_stk[0], 1);
      check_eq("stuck_in_range", v_rng[0], 0);
      check_eq("stuck_overflow", v_ovf[0], 0);
    end

    // Continuous clk/8, continuous dropped mid second-to-third window.
    run(2, 3200, 2500, -1, -1);
    check_eq("cont_nvalid", v_k.size(), 3);
    for (int i = 0; i < v_k.size() && i < 3; i++) begin
      check_eq("cont_k", v_k[i], 1028 + 1027 * i);
      check_eq("cont_count", v_cnt[i], 128);
      check_eq("cont_in_range", v_rng[i], 0);
    end
    check_eq("cont_busy_end", busy_end, 0);

    // Second start during MEASURE ignored; rise on last gate cycle counted,
    // rise one cycle after the window not counted.
    run(3, 1200, 0, 600, -1);
    check_eq("edge_nvalid", v_k.size(), 1);
    if (v_k.size() > 0) begin
      check_eq("edge_latency", v_k[0], 1028);
      check_eq("edge_count", v_cnt[0], 257);
      check_eq("edge_in_range", v_rng[0], 1);
    end
    check_eq("edge_busy_end", busy_end, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule : tb_clk_freq_meter

// File: doc/clk_freq_meter.md
Name: clk_freq_meter

Overview:
- Measures a generated (divided) clock, such as a toggle-flop divider output, in the system clock domain.
- Counts rising edges of the measured signal over a fixed gate window of system clock cycles.
- Reports the count, checks it against an expected range, and flags overflow and stuck-clock faults.
- It is the observer for the clock source generation chain: divider outputs feed in, and status goes to the test/monitor logic.

Parameters:
- GATE_CYCLES, 1024: gate window length in clk cycles; must be ≥ 4.
- CNT_W, 16: width of the edge counter and count_out.
- EXP_MIN, 250: lowest count that asserts in_range (inclusive).
- EXP_MAX, 262: highest count that asserts in_range (inclusive).
- SYNC_STAGES, 2: synchronizer flops on meas_in; must be ≥ 2.

Ports:
- clk, in, 1: system clock; the only clock in the block.
- reset_n, in, 1: asynchronous, active-low reset.
- start, in, 1: one-cycle request to begin a measurement.
- continuous, in, 1: while high, a new window starts automatically after each report.
- meas_in, in, 1: clock under test, asynchronous to clk.
- busy, out, 1: high from accepted start until the report cycle ends.
- count_out, out, CNT_W: edge count of the last completed window; held between reports.
- count_valid, out, 1: one-cycle pulse when count_out updates.
- in_range, out, 1: EXP_MIN ≤ count_out ≤ EXP_MAX; updates with count_out.
- overflow, out, 1: counter saturated during the last window.
- stuck, out, 1: zero edges seen in the last window.

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs 0. Synchronizer flops and the previous-sample flop cleared.
- Input path: meas_in passes through a SYNC_STAGES flop chain, then a previous-sample flop.
  - rise = sync & ~prev.
  - Supported input frequency < clk/2; each high and low phase ≥ 1 clk period. Faster inputs alias; this is not detected.
- State IDLE:
  - start=1 → SETTLE. busy goes high the next cycle.
  - start while busy is ignored (no queue, no restart).
- State SETTLE: SYNC_STAGES cycles to flush stale samples. rise is ignored. Edge count cleared. Then → MEASURE.
- State MEASURE: exactly GATE_CYCLES cycles; the gate counter runs 0..GATE_CYCLES-1.
  - Each cycle with rise=1 increments the edge count.
  - A rise on the final gate cycle is counted.
  - The count saturates at 2^CNT_W-1, and an internal ovf flag sets.
  - On the last gate cycle → REPORT.
- State REPORT (one cycle):
  - count_out, overflow, stuck and in_range are registered. in_range is computed from the final count, and is 0 if overflow=1.
  - count_valid=1 for this cycle.
  - If continuous=1 → SETTLE (busy stays high). Otherwise → IDLE, and busy drops the following cycle.
- Latency: start to count_valid = 1 + SYNC_STAGES + GATE_CYCLES + 1 cycles. With defaults this is 1028.
- continuous deasserted mid-window: the current window completes and reports, then the block returns to IDLE.
- Reset mid-window: aborts immediately. Outputs clear, no count_valid is produced, and the last result is lost.
- Status outputs hold their values until the next REPORT. They are not cleared by start.
- Widths: gate counter is $clog2(GATE_CYCLES) bits. Comparisons are unsigned at CNT_W.

Decomposition:
- Shared package clk_gen_pkg:
  - State enum (IDLE, SETTLE, MEASURE, REPORT).
  - Default gate length and expected-range constants for each divider tap.
- Sub-module sync_edge_det: the synchronizer chain plus rising-edge pulse, parameterised by SYNC_STAGES. It is reusable elsewhere in the clock chain.

Test Plan:
- meas_in = clk/4 (toggles every 2 cycles), GATE=1024, start pulse → count_valid exactly 1028 cycles after start; count_out=256, in_range=1, overflow=0, stuck=0.
- meas_in held at 0 for the whole window → count_out=0, stuck=1, in_range=0.
- CNT_W=4, meas_in = clk/4, GATE=1024 → count_out=15, overflow=1, in_range=0.
- continuous=1, meas_in = clk/8 → count_valid pulses every 1027 cycles with count_out=128. Drop continuous mid-window → one more report, then busy=0.
- Second start pulse during MEASURE, plus a rise aligned to the last gate cycle → start ignored, latency unchanged; the edge is counted (count = expected+1 when aligned).
- reset_n low for 3 cycles mid-MEASURE → all outputs 0 immediately, no count_valid. A new start afterwards measures correctly.
